alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiplier controller that produces `a * b` by shift-and-add. It does the arithmetic on the shared combinational ALU and does not contain its own adder or shifter. It sits beside the execute stage and requests the ALU through a req/gnt handshake, so the core's arbiter can interleave it with normal instructions. Results are truncated to `RegWidth` bits.

---
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned shift-and-add multiplier controller.
// It has no adder or shifter of its own. It borrows the shared combinational
// ALU through a req/gnt handshake, so the core arbiter can interleave it with
// normal instructions. The product is a*b truncated to `RegWidth bits.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, a, b       start a multiply (sampled only in IDLE); operands are
//                     latched when start is accepted
//   busy, done        busy outside IDLE; done is a one-cycle result pulse
//   product           result (the accumulator); valid while done is high
//   alu_req/alu_gnt   ALU handshake; alu_result is valid in the grant cycle
//   alu_op/alu_a/alu_b  ALU command and operands
//   alu_result        combinational ALU output

`ifndef RegWidth
`define RegWidth 32
`endif
`ifndef AluOpWidth
`define AluOpWidth 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 0
`endif
`ifndef ALU_OP_SL
`define ALU_OP_SL 4
`endif

module alu_mul_seq (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [`RegWidth-1:0]   a,
  input  logic [`RegWidth-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [`RegWidth-1:0]   product,
  output logic                   alu_req,
  input  logic                   alu_gnt,
  output logic [`AluOpWidth-1:0] alu_op,
  output logic [`RegWidth-1:0]   alu_a,
  output logic [`RegWidth-1:0]   alu_b,
  input  logic [`RegWidth-1:0]   alu_result
);

  localparam int unsigned W  = `RegWidth;
  localparam int unsigned OW = `AluOpWidth;
  localparam logic [OW-1:0] OP_ADD = OW'(`ALU_OP_ADD);
  localparam logic [OW-1:0] OP_SL  = OW'(`ALU_OP_SL);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    FIN
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] acc;
  logic [W-1:0] mplier_shr;

  assign mplier_shr = mplier >> 1;
  assign product    = acc;

  // Step selection from the remaining multiplier bits: nothing left means
  // finished, a set LSB needs an add first, otherwise just shift.
  function automatic state_t pick_step(input logic [W-1:0] m);
    if (m == '0)
      return FIN;
    else if (m[0])
      return ADD;
    else
      return SHIFT;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
          end
        end
        ADD: begin
          if (alu_gnt)
            acc <= alu_result;
        end
        SHIFT: begin
          if (alu_gnt) begin
            mcand  <= alu_result;
            mplier <= mplier_shr;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU outputs decode from state, acc and mcand only; alu_gnt only steers
  // the next state, so a stalled request holds its command unchanged.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    alu_req   = 1'b0;
    alu_op    = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = pick_step(b);
      end
      ADD: begin
        alu_req = 1'b1;
        alu_op  = OP_ADD;
        alu_a   = acc;
        alu_b   = mcand;
        if (alu_gnt)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        alu_req = 1'b1;
        alu_op  = OP_SL;
        alu_a   = mcand;
        alu_b   = W'(1);
        if (alu_gnt)
          state_nxt = pick_step(mplier_shr);
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq. Provides the shared
// ALU as a combinational model and predicts every cycle of a multiply from
// the bit pattern of b: each multiplier bit up to the MSB costs one shift,
// preceded by an add when the bit is set. A granted step advances the
// prediction; an ungranted step holds it.

`ifndef RegWidth
`define RegWidth 32
`endif
`ifndef AluOpWidth
`define AluOpWidth 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 0
`endif
`ifndef ALU_OP_SL
`define ALU_OP_SL 4
`endif

module tb_alu_mul_seq;

  localparam int unsigned W  = `RegWidth;
  localparam int unsigned OW = `AluOpWidth;
  localparam logic [OW-1:0] OP_ADD = OW'(`ALU_OP_ADD);
  localparam logic [OW-1:0] OP_SL  = OW'(`ALU_OP_SL);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  product;
  logic          alu_req;
  logic          alu_gnt;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model.
  always_comb begin
    if (alu_op == OP_ADD)
      alu_result = alu_a + alu_b;
    else if (alu_op == OP_SL)
      alu_result = alu_a << alu_b;
    else
      alu_result = '0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One multiply, starting from a negedge. stall_first holds gnt low for that
  // many cycles on the first step; rnd adds random stalls and stray starts;
  // pulse26 fires start in cycles 2 and 6; exp_done > 0 pins the done cycle.
  task automatic run_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int stall_first, input bit rnd, input bit pulse26,
                         input int exp_done);
    int unsigned  ops[$];    // 0 = add, 1 = shift
    logic [W-1:0] mc, ac, exp_p;
    int           idx, msb, stall_left, cyc;
    bit           finished;
    msb = -1;
    for (int i = 0; i < int'(W); i++)
      if (tb_v[i]) msb = i;
    for (int i = 0; i <= msb; i++) begin
      if (tb_v[i]) ops.push_back(0);
      ops.push_back(1);
    end
    exp_p = ta * tb_v;
    mc = ta; ac = '0; idx = 0; stall_left = stall_first; finished = 0;
    a = ta; b = tb_v; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk);
    for (cyc = 1; cyc <= int'(4 * W + 64) && !finished; cyc++) begin
      @(negedge clk);
      if (rnd) start = ($urandom_range(0, 5) == 0);
      else     start = pulse26 && (cyc == 2 || cyc == 6);
      a = W'($urandom);
      b = W'($urandom);
      if (cyc == 1) check("product_cleared", product, '0);
      if (idx < ops.size()) begin
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("alu_req", alu_req, 1);
        if (ops[idx] == 0) begin
          check("op_add", alu_op, OP_ADD);
          check("add_a", alu_a, ac);
          check("add_b", alu_b, mc);
        end else begin
          check("op_sl", alu_op, OP_SL);
          check("sl_a", alu_a, mc);
          check("sl_b", alu_b, 1);
        end
        if (stall_left > 0) begin
          alu_gnt = 1'b0;
          stall_left--;
        end else if (rnd) begin
          alu_gnt = ($urandom_range(0, 3) != 0);
        end else begin
          alu_gnt = 1'b1;
        end
        if (alu_gnt) begin
          if (ops[idx] == 0) ac = ac + mc;
          else               mc = mc << 1;
          idx++;
        end
      end else begin
        check("done", done, 1);
        check("busy_fin", busy, 1);
        check("fin_req", alu_req, 0);
        check("fin_op", alu_op, OP_ADD);
        check("fin_a", alu_a, '0);
        check("fin_b", alu_b, '0);
        check("product", product, exp_p);
        if (exp_done > 0) check("done_cycle", cyc, exp_done);
        finished = 1;
      end
    end
    check("done_seen", finished, 1);
    @(negedge clk);
    start = 1'b0;
    alu_gnt = 1'b1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_req", alu_req, 0);
    check("product_hold", product, exp_p);
  endtask

  initial begin
    logic [W-1:0] ra, rb, ones, top;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_gnt = 1'b1;
    ones = '1;
    top  = '0;
    top[W-1] = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, '0);
    check("rst_req", alu_req, 0);
    check("rst_op", alu_op, OP_ADD);
    check("rst_a", alu_a, '0);
    check("rst_b", alu_b, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul(W'(3), W'(5), 0, 0, 0, 6);
    run_mul(W'(9), W'(0), 0, 0, 0, 1);
    run_mul(W'(6), W'(7), 3, 0, 0, 10);
    run_mul(top, W'(2), 0, 0, 0, 4);
    run_mul(W'(1), ones, 0, 0, 0, int'(2 * W + 1));
    run_mul(W'(3), W'(5), 0, 0, 1, 6);

    // Reset in cycle 3 of a 3*5 run, then a clean 4*4.
    a = W'(3); b = W'(5); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_product", product, W'(3));
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_req", alu_req, 0);
    check("arst_product", product, '0);
    check("arst_done", done, 0);
    @(negedge clk);
    check("arst_hold_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    run_mul(W'(4), W'(4), 0, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_mul(ra, rb, 0, 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
